noc_sequencer: RTL and testbench
================================

# noc_sequencer

Synthesizable controller that sequences every router in the mesh through configuration and simulated cycles. On `start` it issues Init, walks the routing-table load across all destinations, then runs the LoadStaging → Phase0 → Phase1 loop once per network cycle until `max_cycle` is reached or every router reports done. It sits above the `router` instances in the NoC top and drives their shared `op` bus and the `in_cycle` counter. Traffic injection may stall it between cycles through `hold`.

## Interface
- `ROUTERS`, 16, number of routers driven.
- `RBITS`, 4, width of a router/destination index; must satisfy 2^RBITS ≥ ROUTERS.
- `CYCLE_BITS`, 16, width of `max_cycle` and `in_cycle`.
- `OP_BITS`, 3, width of the op code (shared op encoding).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- `max_cycle`  in  CYCLE_BITS  number of network cycles to run; sampled on accepted `start`.
- `hold`  in  1  when high at the PH1 exit, the sequencer parks in WAIT instead of entering STAGE.
- `rt_hit`  in  ROUTERS  bit i high = router i has a routing entry for destination `rt_dst`. Combinational from the table.
- `done`  in  ROUTERS  per-router drained/done flags.
- `op`  out  OP_BITS  broadcast router op.
- `op_en`  out  ROUTERS  per-router enable; a router with a low bit treats `op` as NOP.
- `rt_dst`  out  RBITS  destination index being loaded.
- `in_cycle`  out  CYCLE_BITS  completed network cycles.
- `busy`  out  1  high in every state except IDLE and DONE.
- `finished`  out  1  high in DONE.

## Operation
- Op encoding: NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5.
- States: IDLE, INIT, LOADRT, STAGE, PH0, PH1, WAIT, DONE.
- IDLE: `op`=NOP, `op_en`=0. An accepted `start` latches `max_cycle`, clears `in_cycle`, and moves to INIT.
- INIT: one cycle; `op`=Init, `op_en`=all ones. Moves to LOADRT with `rt_dst`=0.
- LOADRT: `op`=LoadRt, `op_en`=`rt_hit`. Lasts exactly ROUTERS cycles, with `rt_dst` running 0..ROUTERS-1.
  - After `rt_dst`=ROUTERS-1, moves to DONE if the latched `max_cycle`=0, otherwise to STAGE.
- STAGE, PH0, PH1: one cycle each; `op` = 3, 4, 5 respectively; `op_en`=all ones.
- PH1 exit, evaluated in this priority order:
  - if `in_cycle`+1 == `max_cycle` or AND(`done`)=1 → DONE;
  - else if `hold` → WAIT;
  - else → STAGE.
  - `in_cycle` increments on every PH1 exit.
- WAIT: `op`=NOP, `op_en`=0. Moves to STAGE in the cycle after `hold` is sampled low.
- DONE: `op`=NOP, `op_en`=0, `finished`=1. `in_cycle` holds its final value. A `start` restarts the run from INIT.
- `start` while busy: ignored, with no effect on state or latched values.

## Timing
- Reset values: state=IDLE, `op`=0, `op_en`=0, `rt_dst`=0, `in_cycle`=0, `busy`=0, `finished`=0. The latched `max_cycle` resets to 0.
- Reset asserted mid-run returns the block to IDLE immediately; no partial op is completed.
- `op`, `rt_dst`, `in_cycle`, `busy` and `finished` are registered, i.e. Moore outputs of the state.
- `op_en` is combinational only in LOADRT (it follows `rt_hit`); in all other states it is decoded from state.
- Latency: `start` sampled at edge N puts `op`=Init in the cycle after edge N. First LoadStaging appears ROUTERS+1 cycles after Init.
- Steady state: one network cycle takes 3 clocks; each WAIT cycle adds 1.
- `in_cycle` never wraps: termination fires before the count passes `max_cycle`. The comparison is CYCLE_BITS wide and unsigned.
- If `done` and `hold` are both high at the PH1 exit, DONE wins.

## Structure
- The op codes and the state encoding belong in the shared parameters include, next to the existing router op definitions.
- One sub-module is natural: `noc_cycle_counter`, holding the latched `max_cycle`, the `in_cycle` register and the terminal-compare logic.
- The FSM and output decode stay in `noc_sequencer`.

## Test plan
- ROUTERS=4, `max_cycle`=2, `hold`=0, `done`=0, `rt_hit`=4'b1111:
  - `op` sequence is 1, 2,2,2,2, 3,4,5, 3,4,5, then 0 with `finished`=1 and `in_cycle`=2;
  - `rt_dst` runs 0,1,2,3 during the LoadRt cycles.
- `rt_hit`=4'b0101 during LOADRT → `op_en`=4'b0101 on all four LoadRt cycles; `op_en`=4'b1111 in STAGE.
- `max_cycle`=0 → after the four LoadRt cycles, DONE is entered directly; no op 3 ever appears; `in_cycle`=0.
- `max_cycle`=10, `done` goes to 4'b1111 before the third PH1 → DONE after that PH1, with `in_cycle`=3.
- `hold` high for 3 clocks spanning the first PH1 exit → `op`=0 with `op_en`=0 for 3 cycles, then `op`=3; the final `in_cycle` count is unaffected.
- `rst_n` pulsed low during PH0 → all outputs read their reset values immediately. A subsequent `start` replays the full Init/LoadRt sequence, and a `start` pulse during PH0 of that run is ignored.

Source files
------------

// File: rtl/noc_sequencer_pkg.sv
// Shared router op codes and sequencer state encoding for the NoC controller.
package noc_sequencer_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP          = 3'd0,
    OP_INIT         = 3'd1,
    OP_LOAD_RT      = 3'd2,
    OP_LOAD_STAGING = 3'd3,
    OP_PHASE0       = 3'd4,
    OP_PHASE1       = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOADRT,
    ST_STAGE,
    ST_PH0,
    ST_PH1,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Broadcast op issued while the sequencer sits in a given state
  function automatic op_e state_op(input state_e s);
    case (s)
      ST_INIT:   return OP_INIT;
      ST_LOADRT: return OP_LOAD_RT;
      ST_STAGE:  return OP_LOAD_STAGING;
      ST_PH0:    return OP_PHASE0;
      ST_PH1:    return OP_PHASE1;
      default:   return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/noc_cycle_counter.sv
// Latched run length, completed-cycle counter and terminal-cycle compare.
module noc_cycle_counter #(
  parameter int CYCLE_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [CYCLE_BITS-1:0] max_cycle,
  output logic [CYCLE_BITS-1:0] in_cycle,
  output logic                  max_zero,
  output logic                  last_cycle
);

  logic [CYCLE_BITS-1:0] max_q;
  logic [CYCLE_BITS-1:0] next_count;

  // Capture the run length on an accepted start and count each completed network cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q    <= '0;
      in_cycle <= '0;
    end else if (load) begin
      max_q    <= max_cycle;
      in_cycle <= '0;
    end else if (advance) begin
      in_cycle <= next_count;
    end
  end

  // The cycle ending now is the last one when the incremented count reaches the limit
  always_comb begin
    next_count = in_cycle + CYCLE_BITS'(1);
    last_cycle = (next_count == max_q);
    max_zero   = (max_q == '0);
  end

endmodule

// File: rtl/noc_sequencer.sv
// Top-level NoC sequencer: Init, routing-table load, then the per-cycle
// LoadStaging/Phase0/Phase1 loop until the cycle limit or all routers are done.
module noc_sequencer
  import noc_sequencer_pkg::*;
#(
  parameter int ROUTERS    = 16,
  parameter int RBITS      = 4,
  parameter int CYCLE_BITS = 16,
  parameter int OP_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CYCLE_BITS-1:0] max_cycle,
  input  logic                  hold,
  input  logic [ROUTERS-1:0]    rt_hit,
  input  logic [ROUTERS-1:0]    done,
  output logic [OP_BITS-1:0]    op,
  output logic [ROUTERS-1:0]    op_en,
  output logic [RBITS-1:0]      rt_dst,
  output logic [CYCLE_BITS-1:0] in_cycle,
  output logic                  busy,
  output logic                  finished
);

  state_e state_q;
  state_e state_d;
  op_e    op_q;
  logic   start_ok;
  logic   rt_last;
  logic   max_zero;
  logic   last_cycle;

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign rt_last  = (rt_dst == RBITS'(ROUTERS - 1));
  assign op       = OP_BITS'(op_q);

  noc_cycle_counter #(
    .CYCLE_BITS(CYCLE_BITS)
  ) u_cycle_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_ok),
    .advance   (state_q == ST_PH1),
    .max_cycle (max_cycle),
    .in_cycle  (in_cycle),
    .max_zero  (max_zero),
    .last_cycle(last_cycle)
  );

  // State register plus registered Moore outputs computed from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      rt_dst   <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= state_op(state_d);
      rt_dst   <= (state_q == ST_LOADRT && state_d == ST_LOADRT) ? rt_dst + RBITS'(1) : '0;
      busy     <= !(state_d == ST_IDLE || state_d == ST_DONE);
      finished <= (state_d == ST_DONE);
    end
  end

  // Next-state selection; at the Phase1 exit termination outranks hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_INIT;
      ST_INIT:          state_d = ST_LOADRT;
      ST_LOADRT:        if (rt_last) state_d = max_zero ? ST_DONE : ST_STAGE;
      ST_STAGE:         state_d = ST_PH0;
      ST_PH0:           state_d = ST_PH1;
      ST_PH1: begin
        if (last_cycle || (&done)) state_d = ST_DONE;
        else if (hold)             state_d = ST_WAIT;
        else                       state_d = ST_STAGE;
      end
      ST_WAIT:          if (!hold) state_d = ST_STAGE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Per-router enables: follow the table hit during the load, otherwise decoded from state
  always_comb begin
    op_en = '0;
    case (state_q)
      ST_LOADRT:                      op_en = rt_hit;
      ST_INIT, ST_STAGE, ST_PH0, ST_PH1: op_en = '1;
      default:                        op_en = '0;
    endcase
  end

endmodule

// File: tb/tb_noc_sequencer.sv
// Directed bench for noc_sequencer with four routers.
module tb_noc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] max_cycle;
  logic        hold;
  logic [3:0]  rt_hit;
  logic [3:0]  done;
  logic [2:0]  op;
  logic [3:0]  op_en;
  logic [1:0]  rt_dst;
  logic [15:0] in_cycle;
  logic        busy;
  logic        finished;

  int errors = 0;
  int checks = 0;

  noc_sequencer #(
    .ROUTERS   (4),
    .RBITS     (2),
    .CYCLE_BITS(16),
    .OP_BITS   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .max_cycle(max_cycle),
    .hold     (hold),
    .rt_hit   (rt_hit),
    .done     (done),
    .op       (op),
    .op_en    (op_en),
    .rt_dst   (rt_dst),
    .in_cycle (in_cycle),
    .busy     (busy),
    .finished (finished)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge and confirm Init is on the bus
  task automatic apply_stimulus(input logic [15:0] limit);
    max_cycle = limit;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("init_op", 32'(op), 32'd1);
    check_output("init_en", 32'(op_en), 32'hF);
    check_output("init_busy", 32'(busy), 32'd1);
  endtask

  // Walk the four LoadRt cycles, checking destination index and enables
  task automatic load_rt(input logic [3:0] exp_en);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("ldrt_op", 32'(op), 32'd2);
      check_output("ldrt_dst", 32'(rt_dst), 32'(i));
      check_output("ldrt_en", 32'(op_en), 32'(exp_en));
    end
  endtask

  task automatic check_done(input logic [15:0] exp_cycle);
    check_output("done_op", 32'(op), 32'd0);
    check_output("done_en", 32'(op_en), 32'd0);
    check_output("done_fin", 32'(finished), 32'd1);
    check_output("done_busy", 32'(busy), 32'd0);
    check_output("done_cycle", 32'(in_cycle), 32'(exp_cycle));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    max_cycle = '0;
    hold = 1'b0;
    rt_hit = 4'hF;
    done = 4'h0;
    repeat (2) tick();
    check_output("rst_op", 32'(op), 32'd0);
    check_output("rst_en", 32'(op_en), 32'd0);
    check_output("rst_dst", 32'(rt_dst), 32'd0);
    check_output("rst_cycle", 32'(in_cycle), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_fin", 32'(finished), 32'd0);
    rst_n = 1'b1;
    tick();
    check_output("idle_op", 32'(op), 32'd0);

    $display("[TB] basic run, max_cycle=2");
    apply_stimulus(16'd2);
    load_rt(4'hF);
    for (int c = 0; c < 2; c++) begin
      tick();
      check_output("stage_op", 32'(op), 32'd3);
      check_output("stage_cycle", 32'(in_cycle), 32'(c));
      tick();
      check_output("ph0_op", 32'(op), 32'd4);
      tick();
      check_output("ph1_op", 32'(op), 32'd5);
      check_output("ph1_en", 32'(op_en), 32'hF);
    end
    tick();
    check_done(16'd2);

    $display("[TB] partial routing hits, max_cycle=1");
    rt_hit = 4'b0101;
    apply_stimulus(16'd1);
    load_rt(4'b0101);
    tick();
    check_output("stage_en", 32'(op_en), 32'hF);
    check_output("stage_op1", 32'(op), 32'd3);
    tick();
    tick();
    tick();
    check_done(16'd1);
    rt_hit = 4'hF;

    $display("[TB] zero-length run");
    apply_stimulus(16'd0);
    load_rt(4'hF);
    tick();
    check_done(16'd0);
    tick();
    check_output("zero_stay_op", 32'(op), 32'd0);

    $display("[TB] early done with hold also high");
    apply_stimulus(16'd10);
    load_rt(4'hF);
    repeat (6) tick();
    tick();
    check_output("early_stage", 32'(op), 32'd3);
    check_output("early_cycle", 32'(in_cycle), 32'd2);
    done = 4'hF;
    hold = 1'b1;
    tick();
    tick();
    check_output("early_ph1", 32'(op), 32'd5);
    tick();
    check_done(16'd3);
    done = 4'h0;
    hold = 1'b0;

    $display("[TB] hold across first Phase1 exit");
    apply_stimulus(16'd2);
    load_rt(4'hF);
    tick();
    tick();
    tick();
    check_output("hold_ph1", 32'(op), 32'd5);
    hold = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      check_output("wait_op", 32'(op), 32'd0);
      check_output("wait_en", 32'(op_en), 32'd0);
      check_output("wait_busy", 32'(busy), 32'd1);
      if (w == 2) hold = 1'b0;
    end
    tick();
    check_output("resume_op", 32'(op), 32'd3);
    check_output("resume_cycle", 32'(in_cycle), 32'd1);
    tick();
    tick();
    tick();
    check_done(16'd2);

    $display("[TB] reset during Phase0, then ignored start");
    apply_stimulus(16'd5);
    load_rt(4'hF);
    tick();
    tick();
    check_output("pre_rst_ph0", 32'(op), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_op", 32'(op), 32'd0);
    check_output("arst_en", 32'(op_en), 32'd0);
    check_output("arst_dst", 32'(rt_dst), 32'd0);
    check_output("arst_cycle", 32'(in_cycle), 32'd0);
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_fin", 32'(finished), 32'd0);
    #2 rst_n = 1'b1;
    apply_stimulus(16'd5);
    load_rt(4'hF);
    tick();
    tick();
    check_output("rerun_ph0", 32'(op), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("ign_ph1", 32'(op), 32'd5);
    check_output("ign_busy", 32'(busy), 32'd1);
    tick();
    check_output("ign_stage", 32'(op), 32'd3);
    check_output("ign_cycle", 32'(in_cycle), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
